// File: rtl/seq_divider_32by16.sv
// Sequential restoring divider, 32-bit dividend / 16-bit divisor, one quotient bit per cycle.
// Latency: done 33 cycles after accept (1 cycle for divide-by-zero); start is ignored while ready=0.
module seq_divider_32by16 #(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          ready,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] q;
   logic [VW-1:0] dvs;
   logic [VW-1:0] pr;
   logic [CW-1:0] cnt;

   logic [VW:0]   t;
   logic          ge;
   logic [VW:0]   diff;
   logic [VW-1:0] pr_nxt;
   logic [DW-1:0] q_nxt;

   // The stored partial remainder is always below the divisor, so its 17th
   // bit is zero between steps; the full 17-bit width lives in t.
   always_comb begin
      t      = {pr, q[DW-1]};
      ge     = (t >= {1'b0, dvs});
      diff   = t - {1'b0, dvs};
      pr_nxt = ge ? diff[VW-1:0] : t[VW-1:0];
      q_nxt  = {q[DW-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (divisor == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt == LAST) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q           <= '0;
         dvs         <= '0;
         pr          <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  q   <= dividend;
                  dvs <= divisor;
                  pr  <= '0;
                  cnt <= '0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend[VW-1:0];
                     div_by_zero <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               q   <= q_nxt;
               pr  <= pr_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  quotient    <= q_nxt;
                  remainder   <= pr_nxt;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready = (state == S_IDLE);
   assign done  = (state == S_DONE);

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Bench for seq_divider_32by16: directed cases, continuous-start throughput, mid-run reset
// and random operands checked against plain-arithmetic division.
module tb_seq_divider_32by16;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        ready;
   logic        done;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider_32by16 dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .ready      (ready),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference result from the arithmetic definition of division.
   task automatic model(input logic [31:0] dvd, input logic [15:0] dvs,
                        output logic [31:0] mq, output logic [15:0] mr, output logic mz);
      if (dvs == 16'd0) begin
         mq = 32'hFFFF_FFFF;
         mr = dvd[15:0];
         mz = 1'b1;
      end else begin
         mq = dvd / {16'd0, dvs};
         mr = 16'(dvd % {16'd0, dvs});
         mz = 1'b0;
      end
   endtask

   // Runs one division from an idle negedge; returns on the negedge after done.
   task automatic do_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [31:0] eq, input logic [15:0] er, input logic ez);
      int n;
      int w;
      int exp_lat;
      w = 0;
      while (ready !== 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_ready_in"}, 64'(ready), 64'd1);
      start    = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      @(negedge clk);
      start = 1'b0;
      exp_lat = (dvs == 16'd0) ? 0 : 32;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         if (n == 1) chk({tag, "_ready_busy"}, 64'(ready), 64'd0);
         start    = (n == 4);
         dividend = $urandom;
         divisor  = 16'($urandom);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
      chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
      chk({tag, "_remainder"}, 64'(remainder), 64'(er));
      chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
      if (dvs != 16'd0) begin
         chk({tag, "_invariant"}, 64'(quotient) * 64'(dvs) + 64'(remainder), 64'(dvd));
         chk({tag, "_rem_lt_dvs"}, 64'(remainder < dvs), 64'd1);
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({tag, "_ready_after"}, 64'(ready), 64'd1);
      chk({tag, "_quotient_hold"}, 64'(quotient), 64'(eq));
   endtask

   logic [31:0] mq;
   logic [15:0] mr;
   logic        mz;
   logic [31:0] acc_dvd[$];
   logic [15:0] acc_dvs[$];
   logic [31:0] rd;
   logic [15:0] rv;
   int          last_acc;
   int          nacc;
   int          sel;
   int          w;

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_quotient", 64'(quotient), 64'd0);
      chk("rst_remainder", 64'(remainder), 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);

      do_div("d100_7", 32'h0000_0064, 16'h0007, 32'h0000_000E, 16'h0002, 1'b0);
      do_div("dmax", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0);
      do_div("d5_9", 32'h0000_0005, 16'h0009, 32'h0000_0000, 16'h0005, 1'b0);
      do_div("dzero", 32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678, 1'b1);
      do_div("dz_clear", 32'h0000_0064, 16'h0007, 32'h0000_000E, 16'h0002, 1'b0);
      do_div("roundtrip", 32'd227776140, 16'd4660, 32'd48879, 16'd0, 1'b0);

      // start held high: only operands present while ready=1 are taken
      start    = 1'b1;
      last_acc = -1;
      nacc     = 0;
      for (int c = 0; c < 107; c++) begin
         dividend = $urandom;
         divisor  = 16'($urandom_range(1, 65535));
         if (done === 1'b1) begin
            model(acc_dvd[0], acc_dvs[0], mq, mr, mz);
            chk("cont_quotient", 64'(quotient), 64'(mq));
            chk("cont_remainder", 64'(remainder), 64'(mr));
            void'(acc_dvd.pop_front());
            void'(acc_dvs.pop_front());
         end
         if (ready === 1'b1) begin
            if (last_acc >= 0) chk("cont_spacing", 64'(c - last_acc), 64'd34);
            last_acc = c;
            nacc++;
            acc_dvd.push_back(dividend);
            acc_dvs.push_back(divisor);
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("cont_accepts", 64'(nacc), 64'd4);
      w = 0;
      while (acc_dvd.size() > 0 && w < 40) begin
         if (done === 1'b1) begin
            model(acc_dvd[0], acc_dvs[0], mq, mr, mz);
            chk("cont_last_quotient", 64'(quotient), 64'(mq));
            chk("cont_last_remainder", 64'(remainder), 64'(mr));
            void'(acc_dvd.pop_front());
            void'(acc_dvs.pop_front());
         end
         @(negedge clk);
         w++;
      end
      chk("cont_drained", 64'(acc_dvd.size()), 64'd0);
      @(negedge clk);

      // reset after iteration 10 aborts the division and drops a coincident start
      start    = 1'b1;
      dividend = 32'h8000_0000;
      divisor  = 16'h0003;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst      = 1'b1;
      start    = 1'b1;
      dividend = 32'h0000_0001;
      divisor  = 16'h0001;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_quotient", 64'(quotient), 64'd0);
      chk("abort_remainder", 64'(remainder), 64'd0);
      chk("abort_dbz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      chk("abort_start_dropped", 64'(ready), 64'd1);
      do_div("after_abort", 32'h0000_0001, 16'h0001, 32'h0000_0001, 16'h0000, 1'b0);

      for (int i = 0; i < 2000; i++) begin
         sel = $urandom_range(0, 15);
         rd  = (sel == 1) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
         if (sel == 0)      rv = 16'd0;
         else if (sel < 6)  rv = 16'($urandom_range(1, 255));
         else               rv = 16'($urandom_range(1, 65535));
         model(rd, rv, mq, mr, mz);
         do_div("rand", rd, rv, mq, mr, mz);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
